// File: rtl/jk_reg_counter.sv
// WIDTH-bit register with per-bit JK semantics plus up/down count and parallel load.
// Counting reuses the JK update with J=K=toggle-chain; tc/wrap support cascading.
module jk_reg_counter #(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic             tc,
  output logic             wrap
);

  localparam logic [1:0] MODE_JK   = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};

  function automatic logic [WIDTH-1:0] jk_apply(
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] j,
    input logic [WIDTH-1:0] k
  );
    return (j & ~q) | (~k & q);
  endfunction

  // Bit i toggles when every lower bit matches the carry (up) or borrow (down) value.
  function automatic logic [WIDTH-1:0] toggle_chain(
    input logic [WIDTH-1:0] q,
    input logic             up
  );
    logic [WIDTH-1:0] t;
    logic             acc;
    acc = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      t[i] = acc;
      acc  = acc & (up ? q[i] : ~q[i]);
    end
    return t;
  endfunction

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] up_tog_s, dn_tog_s;
  logic             tc_s;

  // Next state for Q and terminal-count detection.
  always_comb begin
    up_tog_s = toggle_chain(q_q, 1'b1);
    dn_tog_s = toggle_chain(q_q, 1'b0);
    q_d      = q_q;
    tc_s     = 1'b0;
    if (en) begin
      case (mode)
        MODE_JK:   q_d = jk_apply(q_q, J, K);
        MODE_UP:   q_d = jk_apply(q_q, up_tog_s, up_tog_s);
        MODE_DOWN: q_d = jk_apply(q_q, dn_tog_s, dn_tog_s);
        MODE_LOAD: q_d = D;
        default:   q_d = q_q;
      endcase
      case (mode)
        MODE_UP:   tc_s = (q_q == ALL_ONES);
        MODE_DOWN: tc_s = (q_q == ALL_ZERO);
        default:   tc_s = 1'b0;
      endcase
    end else begin
      q_d  = q_q;
      tc_s = 1'b0;
    end
    // A counting edge taken from the terminal value is exactly a wrap.
    wrap_d = tc_s;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= RESET_VAL;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q    = q_q;
  assign Qbar = ~q_q;
  assign tc   = tc_s;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_jk_reg_counter.sv
// Directed bench for jk_reg_counter: reset values, JK, count wrap, hold, and a
// two-instance cascade; every comparison is an immediate assertion.
module tb_jk_reg_counter;

  logic       clk;
  logic       rst, en;
  logic [1:0] mode;
  logic [3:0] j, k, d;
  logic [3:0] a_q, a_qbar, b_q, b_qbar;
  logic       a_tc, a_wrap, b_tc, b_wrap;

  logic       c_rst;
  logic [3:0] lo_q, lo_qbar, hi_q, hi_qbar;
  logic       lo_tc, lo_wrap, hi_tc, hi_wrap;

  int n_checks;
  int n_errors;
  int wrap_count;
  int wrap_edge;

  jk_reg_counter #(.WIDTH(4), .RESET_VAL(4'b0000)) u_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .J(j), .K(k), .D(d),
    .Q(a_q), .Qbar(a_qbar), .tc(a_tc), .wrap(a_wrap)
  );

  jk_reg_counter #(.WIDTH(4), .RESET_VAL(4'b0101)) u_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .J(j), .K(k), .D(d),
    .Q(b_q), .Qbar(b_qbar), .tc(b_tc), .wrap(b_wrap)
  );

  jk_reg_counter #(.WIDTH(4), .RESET_VAL(4'b0000)) u_lo (
    .clk(clk), .rst(c_rst), .en(1'b1), .mode(2'b01), .J(4'b0000), .K(4'b0000), .D(4'b0000),
    .Q(lo_q), .Qbar(lo_qbar), .tc(lo_tc), .wrap(lo_wrap)
  );

  jk_reg_counter #(.WIDTH(4), .RESET_VAL(4'b0000)) u_hi (
    .clk(clk), .rst(c_rst), .en(lo_tc), .mode(2'b01), .J(4'b0000), .K(4'b0000), .D(4'b0000),
    .Q(hi_q), .Qbar(hi_qbar), .tc(hi_tc), .wrap(hi_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    wrap_count = 0;
    wrap_edge = 0;

    // Reset dominates a pending load of 1111.
    rst = 1'b1; c_rst = 1'b1; en = 1'b1; mode = 2'b11; d = 4'b1111; j = 4'b0000; k = 4'b0000;
    tick();
    tick();
    check("rst_q",      32'(a_q),    32'h0);
    check("rst_qbar",   32'(a_qbar), 32'hF);
    check("rst_wrap",   32'(a_wrap), 32'h0);
    check("rst_tc",     32'(a_tc),   32'h0);
    check("rstval_q",   32'(b_q),    32'h5);
    check("rstval_qbar",32'(b_qbar), 32'hA);

    // JK mode: b3 set, b2 reset, b1 toggle, b0 hold.
    rst = 1'b0; mode = 2'b11; d = 4'b0011;
    tick();
    check("load_0011", 32'(a_q), 32'h3);
    mode = 2'b00; j = 4'b1010; k = 4'b0110;
    tick();
    check("jk_1001", 32'(a_q), 32'h9);
    check("jk_tc",   32'(a_tc), 32'h0);
    j = 4'b0000; k = 4'b0000;
    tick();
    check("jk_hold", 32'(a_q), 32'h9);

    // Up-count wrap.
    mode = 2'b11; d = 4'b1110;
    tick();
    mode = 2'b01;
    tick();
    check("up1_q",    32'(a_q),    32'hF);
    check("up1_tc",   32'(a_tc),   32'h1);
    check("up1_wrap", 32'(a_wrap), 32'h0);
    tick();
    check("up2_q",    32'(a_q),    32'h0);
    check("up2_wrap", 32'(a_wrap), 32'h1);
    check("up2_tc",   32'(a_tc),   32'h0);
    tick();
    check("up3_q",    32'(a_q),    32'h1);
    check("up3_wrap", 32'(a_wrap), 32'h0);

    // Down-count wrap.
    mode = 2'b11; d = 4'b0001;
    tick();
    mode = 2'b10;
    tick();
    check("dn1_q",    32'(a_q),    32'h0);
    check("dn1_tc",   32'(a_tc),   32'h1);
    check("dn1_wrap", 32'(a_wrap), 32'h0);
    tick();
    check("dn2_q",    32'(a_q),    32'hF);
    check("dn2_wrap", 32'(a_wrap), 32'h1);
    tick();
    check("dn3_q",    32'(a_q),    32'hE);
    check("dn3_wrap", 32'(a_wrap), 32'h0);

    // An all-ones to zero change in JK mode is not a wrap.
    mode = 2'b11; d = 4'b1111;
    tick();
    mode = 2'b00; j = 4'b0000; k = 4'b1111;
    tick();
    check("jk_clr_q",    32'(a_q),    32'h0);
    check("jk_clr_wrap", 32'(a_wrap), 32'h0);

    // Count to 0110, hold, then reset mid-count.
    mode = 2'b11; d = 4'b0000;
    tick();
    mode = 2'b01;
    for (int i = 0; i < 6; i++) tick();
    check("cnt_6", 32'(a_q), 32'h6);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_q",    32'(a_q),    32'h6);
      check("hold_wrap", 32'(a_wrap), 32'h0);
      check("hold_tc",   32'(a_tc),   32'h0);
    end
    en = 1'b1; rst = 1'b1;
    tick();
    check("midrst_q", 32'(a_q), 32'h0);
    rst = 1'b0;
    tick();
    check("resume_q", 32'(a_q), 32'h1);

    // Cascade: 20 edges from zero.
    c_rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (lo_wrap === 1'b1) begin
        wrap_count++;
        wrap_edge = i;
      end
    end
    check("cascade_val",  32'({hi_q, lo_q}), 32'h14);
    check("cascade_wrapn", 32'(wrap_count),  32'd1);
    check("cascade_wrape", 32'(wrap_edge),   32'd16);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
